spi_drv: RTL and testbench
==========================

Name: spi_drv

Overview:
- Single-transaction SPI master driver, SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- On a start command it asserts SS_N and shifts out a programmable number of bits (1..SPI_MAXLEN) on MOSI. In the same clocks it captures MISO.
- Returns the received word on rx_miso and raises spi_drv_rdy when done.
- Sits between a command/control FSM and an external SPI slave pin interface.

Parameters:
- CLK_DIVIDE, default 4: system clocks per SCLK period. Must be even and >= 2. HALF = CLK_DIVIDE/2.
- SPI_MAXLEN, default 8: maximum transfer length in bits; sets the data port widths.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- sresetn  in  1  synchronous active-low reset.
- start_cmd  in  1  transfer request; level, sampled only while spi_drv_rdy=1.
- spi_drv_rdy  out  1  1 = idle, a command can be accepted.
- n_clks  in  $clog2(SPI_MAXLEN)+1  number of bits/SCLK pulses; sampled at acceptance.
- tx_data  in  SPI_MAXLEN  transmit word, right-aligned; bits [n_clks-1:0] are sent; sampled at acceptance.
- rx_miso  out  SPI_MAXLEN  received word, right-aligned; upper bits zero.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SS_N  out  1  active-low slave select.

Behaviour:
- Interface: one clock clk, synchronous active-low reset sresetn.
- Reset, when sresetn=0 at a clk edge:
  - SS_N=1, SCLK=0, MOSI=0, spi_drv_rdy=1, rx_miso=0, FSM to IDLE.
  - Reset mid-transfer aborts immediately; rx_miso is cleared.
- All outputs are registered.
- States: IDLE, LEAD, XFER, TRAIL.
- IDLE:
  - Outputs: rdy=1, SS_N=1, SCLK=0.
  - Acceptance condition: start_cmd=1 and 1 <= n_clks.
  - On acceptance: latch tx_data and len = min(n_clks, SPI_MAXLEN), clear the bit counter.
  - Next cycle: rdy=0, SS_N=0, MOSI=tx_data[len-1], enter LEAD.
  - n_clks=0: command ignored, rdy stays 1.
- LEAD: lasts HALF cycles, SCLK=0, MOSI holds the first bit.
- XFER, each bit is one CLK_DIVIDE-cycle period:
  - SCLK high for HALF cycles, then low for HALF cycles.
  - Rising SCLK: on the clk edge that drives SCLK 0->1, sample MISO into the receive shift register (shift left, new bit at LSB).
  - Falling SCLK: on the clk edge that drives SCLK 1->0, MOSI advances to the next lower bit, unless the last bit has been sent.
  - After len periods, go to TRAIL.
- TRAIL:
  - HALF cycles with SS_N=0, SCLK=0, MOSI holding the last bit.
  - Then SS_N=1, rdy=1, MOSI=0, and rx_miso loads the received word, all in the same cycle; return to IDLE.
- Timing:
  - SS_N low duration = CLK_DIVIDE*len + 2*HALF cycles. Example: CLK_DIVIDE=4, len=8 gives 36 cycles.
  - Exactly len rising SCLK edges per transfer.
- rx_miso holds its last value during a transfer and between transfers. It changes only at transfer end or reset.
- start_cmd is ignored while rdy=0. Holding start_cmd high for several cycles after acceptance does not start a second transfer during the current one.
- If start_cmd is still 1 on the cycle rdy returns to 1, a new transfer is accepted on that cycle (back-to-back allowed).
- n_clks and tx_data changes after acceptance have no effect on the current transfer.

Test Plan:
- Byte loopback:
  - Stimulus: CLK_DIVIDE=4, n_clks=8, tx_data=0xAB, MISO tied to MOSI, start_cmd pulsed 1 cycle.
  - Required: MOSI sequence 1,0,1,0,1,0,1,1; 8 SCLK pulses of 4 clk period; SS_N low 36 cycles; rx_miso=0xAB; rdy back to 1.
- Short transfer:
  - Stimulus: n_clks=4, tx_data=0xA5, loopback.
  - Required: MOSI 0,1,0,1; 4 SCLK pulses; rx_miso=0x05.
- Held start:
  - Stimulus: start_cmd held 2 cycles, n_clks=8.
  - Required: exactly one transaction, 8 SCLK pulses, rdy low throughout.
- MISO constant:
  - Stimulus: MISO=1, n_clks=3.
  - Required: rx_miso=0x07.
  - Stimulus: random MISO changed on falling SCLK.
  - Required: rx_miso matches the bits present at each rising SCLK.
- Zero length:
  - Stimulus: n_clks=0 with start_cmd=1.
  - Required: no SS_N assertion, rdy stays 1.
- Reset mid-transfer:
  - Stimulus: sresetn=0 during XFER.
  - Required: next edge gives SS_N=1, SCLK=0, rdy=1, rx_miso=0; a following transfer works normally.

Source files
------------

// File: rtl/spi_drv.sv
// SPI mode-0 master: one MSB-first transfer of 1..SPI_MAXLEN bits per accepted start command.
// MISO is captured on every rising SCLK, and the received word is published when SS_N releases.
module spi_drv #(
  parameter int CLK_DIVIDE = 4,
  parameter int SPI_MAXLEN = 8
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          start_cmd,
  output logic                          spi_drv_rdy,
  input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
  input  logic [SPI_MAXLEN-1:0]         tx_data,
  output logic [SPI_MAXLEN-1:0]         rx_miso,
  output logic                          SCLK,
  output logic                          MOSI,
  input  logic                          MISO,
  output logic                          SS_N
);

  localparam int HALF = CLK_DIVIDE / 2;
  localparam int LW   = $clog2(SPI_MAXLEN) + 1;
  localparam int CW   = (CLK_DIVIDE > 2) ? $clog2(CLK_DIVIDE) : 1;

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] PER_END  = CW'(CLK_DIVIDE - 1);
  localparam logic [LW-1:0] MAXLEN   = LW'(SPI_MAXLEN);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         bit_q, bit_d;
  logic [LW-1:0]         len_q, len_d;
  logic [SPI_MAXLEN-1:0] tx_q, tx_d;
  logic [SPI_MAXLEN-1:0] rxsh_q, rxsh_d;
  logic [SPI_MAXLEN-1:0] rx_q, rx_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ssn_q, ssn_d;
  logic                  rdy_q, rdy_d;

  logic [LW-1:0]         lenAccept;
  logic [LW-1:0]         shiftAmt;
  logic [SPI_MAXLEN-1:0] txAligned;
  logic [SPI_MAXLEN-1:0] txShift;
  logic [SPI_MAXLEN-1:0] rxShift;
  logic [LW-1:0]         bitNext;

  // The transmit word is left-aligned at acceptance so the current bit is always the MSB.
  always_comb begin
    lenAccept = (n_clks > MAXLEN) ? MAXLEN : n_clks;
    shiftAmt  = MAXLEN - lenAccept;
    txAligned = tx_data << shiftAmt;
    txShift   = tx_q << 1;
    rxShift   = (rxsh_q << 1) | SPI_MAXLEN'(MISO);
    bitNext   = bit_q + ONE_L;
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      tx_q    <= '0;
      rxsh_q  <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ssn_q   <= 1'b1;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      tx_q    <= tx_d;
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ssn_q   <= ssn_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    len_d   = len_q;
    tx_d    = tx_q;
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ssn_d   = ssn_q;
    rdy_d   = rdy_q;

    case (state_q)
      IDLE: begin
        if (start_cmd && (n_clks != '0)) begin
          state_d = LEAD;
          cnt_d   = '0;
          bit_d   = '0;
          len_d   = lenAccept;
          tx_d    = txAligned;
          rxsh_d  = '0;
          sclk_d  = 1'b0;
          mosi_d  = txAligned[SPI_MAXLEN-1];
          ssn_d   = 1'b0;
          rdy_d   = 1'b0;
        end
      end

      LEAD: begin
        if (cnt_q == HALF_END) begin
          state_d = XFER;
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rxsh_d  = rxShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Within each bit period: falling SCLK at the half point, next rising at the period end.
      XFER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_END) begin
          sclk_d = 1'b0;
          bit_d  = bitNext;
          if (bitNext != len_q) begin
            tx_d   = txShift;
            mosi_d = txShift[SPI_MAXLEN-1];
          end
        end
        if (cnt_q == PER_END) begin
          cnt_d = '0;
          if (bit_q == len_q) begin
            state_d = TRAIL;
          end else begin
            sclk_d = 1'b1;
            rxsh_d = rxShift;
          end
        end
      end

      TRAIL: begin
        if (cnt_q == HALF_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          ssn_d   = 1'b1;
          rdy_d   = 1'b1;
          mosi_d  = 1'b0;
          rx_d    = rxsh_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign spi_drv_rdy = rdy_q;
  assign rx_miso     = rx_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign SS_N        = ssn_q;

endmodule

// File: tb/tb_spi_drv.sv
// Self-checking bench for spi_drv: directed vector table, hand-written corner sequences,
// and randomized transfers scored against a bit-level model of an SPI mode-0 transaction.
module tb_spi_drv;

  localparam int CD    = 4;
  localparam int MAXL  = 8;
  localparam int LW    = 4;
  localparam int LOOP  = 0;
  localparam int ONES  = 1;
  localparam int ZEROS = 2;
  localparam int RAND  = 3;

  logic          clk = 1'b0;
  logic          sresetn;
  logic          start_cmd;
  logic          spi_drv_rdy;
  logic [LW-1:0] n_clks;
  logic [7:0]    tx_data;
  logic [7:0]    rx_miso;
  logic          SCLK;
  logic          MOSI;
  logic          MISO;
  logic          SS_N;

  logic          loopEn;
  logic          misoDrv;
  logic          misoBits [MAXL];

  int nCompared   = 0;
  int nMismatched = 0;

  assign MISO = loopEn ? MOSI : misoDrv;

  always #5 clk = ~clk;

  spi_drv #(
    .CLK_DIVIDE(CD),
    .SPI_MAXLEN(MAXL)
  ) dut (
    .clk        (clk),
    .sresetn    (sresetn),
    .start_cmd  (start_cmd),
    .spi_drv_rdy(spi_drv_rdy),
    .n_clks     (n_clks),
    .tx_data    (tx_data),
    .rx_miso    (rx_miso),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .SS_N       (SS_N)
  );

  typedef struct {
    int         nc;
    logic [7:0] tx;
    int         mode;
    int         hold;
    logic [7:0] expRx;
    int         expLen;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction: optionally issue the command, then watch the pins every cycle.
  task automatic applyStimulus(input int nc, input logic [7:0] tx, input int mode, input int hold,
                               input bit keepStart, input bit alreadyStarted,
                               input logic [7:0] expRx, input int expLen);
    logic [7:0] rxBefore, mosiWord, mask, t;
    logic       prevSclk, lastMosi, firstMosi;
    int         ssLow, rises, highCnt, periodBad, rdyBad, rxBad, lastRise;
    bit         done;
    mask      = 8'((1 << expLen) - 1);
    loopEn    = (mode == LOOP);
    misoDrv   = (mode == ONES) ? 1'b1 : ((mode == RAND) ? misoBits[0] : 1'b0);
    rxBefore  = rx_miso;
    mosiWord  = '0;
    prevSclk  = 1'b0;
    lastMosi  = 1'b0;
    firstMosi = 1'b0;
    ssLow = 0; rises = 0; highCnt = 0; periodBad = 0; rdyBad = 0; rxBad = 0; lastRise = 0;
    done = 1'b0;
    if (!alreadyStarted) begin
      @(negedge clk);
      n_clks    = LW'(nc);
      tx_data   = tx;
      start_cmd = 1'b1;
    end
    for (int i = 1; i <= 100 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checkOutput("accept_ssn", 32'(SS_N), 32'(0));
        checkOutput("accept_rdy", 32'(spi_drv_rdy), 32'(0));
        firstMosi = MOSI;
        if (!keepStart) begin
          tx_data = 8'($urandom);
          n_clks  = LW'($urandom_range(0, 15));
        end
      end
      if (!keepStart && i >= hold) start_cmd = 1'b0;
      if (SS_N) begin
        done = 1'b1;
      end else begin
        ssLow++;
        lastMosi = MOSI;
        if (spi_drv_rdy !== 1'b0) rdyBad++;
        if (rx_miso !== rxBefore) rxBad++;
        if (SCLK && !prevSclk) begin
          rises++;
          mosiWord = {mosiWord[6:0], MOSI};
          if (rises > 1 && (i - lastRise) != CD) periodBad++;
          lastRise = i;
        end
        if (SCLK) highCnt++;
        if (!SCLK && prevSclk && mode == RAND && rises < expLen) misoDrv = misoBits[rises];
        prevSclk = SCLK;
      end
    end
    t = tx >> (expLen - 1);
    checkOutput("done_ssn", 32'(SS_N), 32'(1));
    checkOutput("ssn_low_cycles", 32'(ssLow), 32'(CD * expLen + CD));
    checkOutput("sclk_rises", 32'(rises), 32'(expLen));
    checkOutput("sclk_high_cycles", 32'(highCnt), 32'(expLen * CD / 2));
    checkOutput("sclk_period_errs", 32'(periodBad), 32'(0));
    checkOutput("rdy_during_xfer", 32'(rdyBad), 32'(0));
    checkOutput("rx_stable_during_xfer", 32'(rxBad), 32'(0));
    checkOutput("lead_mosi", 32'(firstMosi), 32'(t[0]));
    checkOutput("mosi_bits", 32'(mosiWord), 32'(tx & mask));
    checkOutput("trail_mosi", 32'(lastMosi), 32'(tx[0]));
    checkOutput("end_rdy", 32'(spi_drv_rdy), 32'(1));
    checkOutput("end_mosi", 32'(MOSI), 32'(0));
    checkOutput("end_sclk", 32'(SCLK), 32'(0));
    checkOutput("rx_miso", 32'(rx_miso), 32'(expRx));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         nc, len, mode, hold, zeroSsn, zeroRdy;
    logic [7:0] tx, mask, expRx;

    vecs[0] = '{8,  8'hAB, LOOP,  1, 8'hAB, 8};
    vecs[1] = '{4,  8'hA5, LOOP,  1, 8'h05, 4};
    vecs[2] = '{8,  8'h3C, LOOP,  2, 8'h3C, 8};
    vecs[3] = '{3,  8'h00, ONES,  1, 8'h07, 3};
    vecs[4] = '{1,  8'h01, LOOP,  1, 8'h01, 1};
    vecs[5] = '{1,  8'hFE, LOOP,  1, 8'h00, 1};
    vecs[6] = '{12, 8'h96, LOOP,  1, 8'h96, 8};
    vecs[7] = '{8,  8'hFF, ZEROS, 3, 8'h00, 8};
    vecs[8] = '{5,  8'hE0, ONES,  1, 8'h1F, 5};

    sresetn   = 1'b0;
    start_cmd = 1'b0;
    n_clks    = '0;
    tx_data   = '0;
    loopEn    = 1'b0;
    misoDrv   = 1'b0;
    for (int k = 0; k < MAXL; k++) misoBits[k] = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ssn", 32'(SS_N), 32'(1));
    checkOutput("reset_sclk", 32'(SCLK), 32'(0));
    checkOutput("reset_mosi", 32'(MOSI), 32'(0));
    checkOutput("reset_rdy", 32'(spi_drv_rdy), 32'(1));
    checkOutput("reset_rx", 32'(rx_miso), 32'(0));
    sresetn = 1'b1;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].nc, vecs[v].tx, vecs[v].mode, vecs[v].hold, 1'b0, 1'b0,
                    vecs[v].expRx, vecs[v].expLen);
      @(negedge clk);
      checkOutput("idle_after_xfer", 32'(SS_N), 32'(1));
    end

    // Zero-length command must be ignored entirely.
    @(negedge clk);
    n_clks    = '0;
    tx_data   = 8'hFF;
    start_cmd = 1'b1;
    zeroSsn   = 0;
    zeroRdy   = 0;
    repeat (6) begin
      @(negedge clk);
      if (SS_N !== 1'b1) zeroSsn++;
      if (spi_drv_rdy !== 1'b1) zeroRdy++;
    end
    start_cmd = 1'b0;
    checkOutput("zero_len_ssn_low", 32'(zeroSsn), 32'(0));
    checkOutput("zero_len_rdy_low", 32'(zeroRdy), 32'(0));

    // Back-to-back: start held through the end of one transfer launches the next at once.
    applyStimulus(8, 8'hC3, LOOP, 1, 1'b1, 1'b0, 8'hC3, 8);
    applyStimulus(8, 8'hC3, LOOP, 1, 1'b0, 1'b1, 8'hC3, 8);

    // Reset in the middle of a transfer aborts and clears the received word.
    applyStimulus(8, 8'hAB, LOOP, 1, 1'b0, 1'b0, 8'hAB, 8);
    @(negedge clk);
    n_clks    = 4'd8;
    tx_data   = 8'h5A;
    start_cmd = 1'b1;
    @(negedge clk);
    start_cmd = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("pre_reset_ssn", 32'(SS_N), 32'(0));
    sresetn = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ssn", 32'(SS_N), 32'(1));
    checkOutput("midreset_sclk", 32'(SCLK), 32'(0));
    checkOutput("midreset_rdy", 32'(spi_drv_rdy), 32'(1));
    checkOutput("midreset_rx", 32'(rx_miso), 32'(0));
    checkOutput("midreset_mosi", 32'(MOSI), 32'(0));
    sresetn = 1'b1;
    applyStimulus(6, 8'h2D, LOOP, 1, 1'b0, 1'b0, 8'h2D, 6);

    // Randomized transfers against the reference model of a mode-0 transaction.
    for (int r = 0; r < 24; r++) begin
      nc   = $urandom_range(1, 15);
      tx   = 8'($urandom);
      mode = $urandom_range(0, 3);
      hold = $urandom_range(1, 3);
      for (int k = 0; k < MAXL; k++) misoBits[k] = 1'($urandom_range(0, 1));
      len  = (nc > MAXL) ? MAXL : nc;
      mask = 8'((1 << len) - 1);
      case (mode)
        LOOP:    expRx = tx & mask;
        ONES:    expRx = mask;
        ZEROS:   expRx = 8'h00;
        default: begin
          expRx = 8'h00;
          for (int k = 0; k < len; k++) expRx = {expRx[6:0], misoBits[k]};
        end
      endcase
      applyStimulus(nc, tx, mode, hold, 1'b0, 1'b0, expRx, len);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
